fp_mac_sequencer: RTL and testbench
===================================

// Module: fp_mac_sequencer
// PURPOSE
//  Controls the floating-point MAC datapath for one dot product of vec_len operand pairs.
//  - Accepts a start command.
//  - Pulls operand pairs from an upstream valid/ready stream.
//  - Issues each pair to the MAC, spaced to respect the accumulator loop latency.
//  - Drains the pipeline, then holds the final IEEE-754 single result until downstream accepts it.
//  - Sits between the operand buffer and the MAC pipeline; its output feeds the result register stage.
// PARAMETERS
//  LEN_W     8  width of vec_len and of the element counters
//  PIPE_LAT  3  cycles from mac_issue to the matching sum on mac_result (>=1)
// PORTS
//  clock        in   1      system clock, rising edge
//  resetn       in   1      asynchronous active-low reset
//  start        in   1      begin a dot product; sampled only in IDLE
//  vec_len      in   LEN_W  number of pairs; sampled with start
//  in_valid     in   1      upstream operand pair valid
//  in_ready     out  1      sequencer accepts a pair this cycle
//  mac_issue    out  1      datapath captures the operand pair (= in_valid & in_ready)
//  mac_first    out  1      with mac_issue: datapath seeds accumulator with 0 (first pair)
//  mac_result   in   32     datapath accumulated sum, 32-bit float
//  out_valid    out  1      out_result valid, held until out_ready
//  out_ready    in   1      downstream accepts result
//  out_result   out  32     final dot-product value
//  busy         out  1      high in every state except IDLE
//  issued_cnt   out  LEN_W  pairs issued in current operation
// BEHAVIOUR
//  Reset values: state=IDLE; in_ready, mac_issue, mac_first, out_valid, busy = 0;
//    out_result, issued_cnt, remaining, gap = 0. Reset mid-operation aborts immediately; no result is produced.
//  States: IDLE -> ISSUE -> DRAIN -> OUT -> IDLE.
//  IDLE
//    - start=1 & vec_len!=0: latch remaining=vec_len, clear issued_cnt and gap, go to ISSUE.
//    - start=1 & vec_len==0: load out_result=32'h0000_0000 and go to OUT (no MAC activity).
//  ISSUE
//    - in_ready = (gap==0). Issue occurs when in_valid & in_ready.
//    - On issue: mac_issue=1; mac_first=1 iff issued_cnt==0; issued_cnt+1; remaining-1; gap<=PIPE_LAT-1.
//    - gap decrements by 1 each cycle while nonzero.
//    - Result: with PIPE_LAT=1 a pair can issue every cycle; otherwise one issue per PIPE_LAT cycles.
//    - Issue with remaining==1 (last pair): go to DRAIN.
//    - in_valid low simply stalls; no timeout.
//  DRAIN
//    - in_ready=0. gap counts down.
//    - In the cycle gap==0, which is exactly PIPE_LAT cycles after the last issue:
//      out_result<=mac_result; go to OUT.
//  OUT
//    - out_valid=1; out_result stable.
//    - out_ready=1: drop out_valid and return to IDLE. Next start is accepted the following cycle.
//  start outside IDLE is ignored; vec_len changes outside IDLE are ignored.
//  issued_cnt holds its final value in OUT and IDLE until the next accepted start.
//  in_ready is registered-state based only; it has no combinational path from in_valid.
//  out_ready=1 while out_valid=0 has no effect.
// TESTING
//  T1 reset: resetn=0 mid-ISSUE after 2 issues -> all outputs 0, state IDLE; later start works normally.
//  T2 vec_len=3, PIPE_LAT=3, in_valid held 1:
//     - issues at cycles t, t+3, t+6; mac_first only at t;
//     - mac_result sampled at t+9; out_valid=1 at t+10; issued_cnt=3.
//  T3 vec_len=0:
//     - out_valid=1 one cycle after start, out_result=32'h0;
//     - mac_issue never asserts.
//  T4 backpressure, vec_len=2:
//     - in_valid low 5 cycles after first issue -> no issue; second issue when in_valid rises;
//     - out_ready low 4 cycles -> out_valid and out_result held; start pulses during busy ignored.
//  T5 PIPE_LAT=1, vec_len=4, products 1.0,2.0,3.0,4.0 via datapath model:
//     - issues on 4 consecutive cycles;
//     - out_result=32'h4120_0000 (10.0).
//  T6 back-to-back operations:
//     - start asserted the cycle after out handshake -> second op runs;
//     - mac_first asserts again on its first issue.

Source files
------------

// File: rtl/fp_mac_sequencer.sv
// Sequencer for one floating-point dot product: pulls operand pairs, spaces MAC issues by the
// accumulator loop latency, drains the pipeline and holds the final sum until it is accepted.
module fp_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_issue,
    output logic             mac_first,
    input  logic [31:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             busy,
    output logic [LEN_W-1:0] issued_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam int              GAP_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(PIPE_LAT - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [31:0]        result_q, result_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               issue;

    assign issue = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        gap_d       = gap_q;
        result_d    = result_q;

        // gap is the number of cycles still to wait before the accumulator can take a new pair
        if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    issued_d = '0;
                    gap_d    = '0;
                    if (vec_len != '0) begin
                        remaining_d = vec_len;
                        state_d     = S_ISSUE;
                    end else begin
                        result_d = 32'h0000_0000;
                        state_d  = S_OUT;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    issued_d    = issued_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    gap_d       = GAP_RELOAD;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (gap_q == '0) begin
                    result_d = mac_result;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are decoded from the next state so they leave the flops glitch-free
        in_ready_d  = (state_d == S_ISSUE) && (gap_d == '0);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            issued_q    <= '0;
            gap_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            gap_q       <= gap_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mac_issue  = issue;
    assign mac_first  = issue & (issued_q == '0);
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign busy       = busy_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Randomised bench: two sequencers (loop latency 3 and 1) each driving an integer-valued
// accumulator model; timing and results are predicted from the issue-spacing rules.
module tb_fp_mac_sequencer;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic [1:0]        start_v;
    logic [7:0]        vec_len_v [2];
    logic [1:0]        in_valid_v;
    logic [1:0]        in_ready_v;
    logic [1:0]        mac_issue_v;
    logic [1:0]        mac_first_v;
    logic [31:0]       mac_result_v [2];
    logic [1:0]        out_valid_v;
    logic [1:0]        out_ready_v;
    logic [31:0]       out_result_v [2];
    logic [1:0]        busy_v;
    logic [7:0]        issued_cnt_v [2];
    int unsigned       in_a_v [2];
    int unsigned       in_b_v [2];

    int unsigned       pa [16];
    int unsigned       pb [16];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] int_to_f32(input int unsigned v);
        int          msb;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (v[i]) msb = i;
        m = (msb <= 23) ? (v << (23 - msb)) : (v >> (msb - 23));
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? LAT0 : LAT1;
        logic [31:0]  hist [64];
        int unsigned  acc = 0;
        int unsigned  acc_next;

        fp_mac_sequencer #(
            .LEN_W    (8),
            .PIPE_LAT (LAT)
        ) u_dut (
            .clock      (clk),
            .resetn     (resetn),
            .start      (start_v[gi]),
            .vec_len    (vec_len_v[gi]),
            .in_valid   (in_valid_v[gi]),
            .in_ready   (in_ready_v[gi]),
            .mac_issue  (mac_issue_v[gi]),
            .mac_first  (mac_first_v[gi]),
            .mac_result (mac_result_v[gi]),
            .out_valid  (out_valid_v[gi]),
            .out_ready  (out_ready_v[gi]),
            .out_result (out_result_v[gi]),
            .busy       (busy_v[gi]),
            .issued_cnt (issued_cnt_v[gi])
        );

        // Datapath: the sum including a pair issued in cycle c is visible on mac_result in c+LAT
        assign acc_next = (mac_first_v[gi] ? 32'd0 : acc) + in_a_v[gi] * in_b_v[gi];
        assign mac_result_v[gi] = hist[6'(cyc - LAT)];

        always @(posedge clk) begin
            if (mac_issue_v[gi]) acc <= acc_next;
            hist[6'(cyc)] <= int_to_f32(mac_issue_v[gi] ? acc_next : acc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int d);
        check_val("rst_in_ready", in_ready_v[d], 0);
        check_val("rst_mac_issue", mac_issue_v[d], 0);
        check_val("rst_mac_first", mac_first_v[d], 0);
        check_val("rst_out_valid", out_valid_v[d], 0);
        check_val("rst_busy", busy_v[d], 0);
        check_val("rst_issued_cnt", issued_cnt_v[d], 0);
        check_val("rst_out_result", out_result_v[d], 0);
    endtask

    task automatic idle(input int d, input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            start_v[d]    = 1'b0;
            in_valid_v[d] = 1'($urandom);
            out_ready_v[d] = 1'($urandom);
            #1;
            check_val("idle_busy", busy_v[d], 0);
            check_val("idle_in_ready", in_ready_v[d], 0);
            check_val("idle_mac_issue", mac_issue_v[d], 0);
        end
    endtask

    // vmode: 0 = in_valid held high, 1 = random, 2 = low for 5 cycles after the first issue
    task automatic run_op(input int d, input int n, input int vmode, input int rdelay,
                          input bit fixed);
        int          lat, issued, last_iss, first_iss, c;
        int unsigned sum;
        logic [31:0] exp_res;
        bit          done, can, ov_exp, iv;

        lat = (d == 0) ? LAT0 : LAT1;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            pa[i] = fixed ? 32'(i + 1) : $urandom_range(0, 15);
            pb[i] = fixed ? 32'd1 : $urandom_range(0, 15);
            sum += pa[i] * pb[i];
        end
        exp_res = int_to_f32(sum);

        @(negedge clk);
        start_v[d]     = 1'b1;
        vec_len_v[d]   = 8'(n);
        in_valid_v[d]  = 1'($urandom);
        out_ready_v[d] = 1'($urandom);
        #1;
        check_val("start_busy", busy_v[d], 0);
        check_val("start_out_valid", out_valid_v[d], 0);
        check_val("start_no_issue", mac_issue_v[d], 0);

        issued = 0; last_iss = 0; first_iss = 0; c = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            c++;
            start_v[d]   = 1'($urandom);
            vec_len_v[d] = 8'($urandom);
            ov_exp = (n == 0) ? 1'b1 : (issued == n && c >= last_iss + lat + 1);
            can    = !ov_exp && issued < n && (issued == 0 || c >= last_iss + lat);
            if (vmode == 0)      iv = 1'b1;
            else if (vmode == 1) iv = 1'($urandom);
            else                 iv = !(issued == 1 && c <= first_iss + 5);
            in_valid_v[d]  = iv;
            in_a_v[d]      = (issued < n) ? pa[issued] : 0;
            in_b_v[d]      = (issued < n) ? pb[issued] : 0;
            out_ready_v[d] = ov_exp ? 1'b0 : 1'($urandom);
            #1;
            if (c > 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL op_timeout: dut %0d len %0d stuck after %0d cycles", d, n, c);
                return;
            end
            if (ov_exp) begin
                done = 1'b1;
            end else begin
                check_val("in_ready", in_ready_v[d], 32'(can));
                check_val("mac_issue", mac_issue_v[d], 32'(can & iv));
                check_val("early_out_valid", out_valid_v[d], 0);
                check_val("busy", busy_v[d], 1);
                if (can && iv) begin
                    check_val("mac_first", mac_first_v[d], 32'(issued == 0));
                    if (issued == 0) first_iss = c;
                    last_iss = c;
                    issued++;
                end
            end
        end

        for (int k = 0; k <= rdelay; k++) begin
            if (k > 0) begin
                @(negedge clk);
                in_valid_v[d] = 1'($urandom);
                vec_len_v[d]  = 8'($urandom);
            end
            start_v[d]     = (k == rdelay) ? 1'b0 : 1'($urandom);
            out_ready_v[d] = (k == rdelay);
            #1;
            check_val("out_valid", out_valid_v[d], 1);
            check_val("out_result", out_result_v[d], exp_res);
            check_val("out_busy", busy_v[d], 1);
            check_val("out_no_issue", mac_issue_v[d], 0);
            if (n > 0) check_val("issued_cnt", issued_cnt_v[d], 32'(n));
        end
        $display("op dut=%0d len=%0d vmode=%0d rdelay=%0d result=%08h", d, n, vmode, rdelay,
                 out_result_v[d]);
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        start_v[0]    = 1'b1;
        vec_len_v[0]  = 8'd4;
        in_valid_v[0] = 1'b1;
        in_a_v[0]     = 2;
        in_b_v[0]     = 3;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_val("pre_rst_issued", issued_cnt_v[0], 2);
        check_val("pre_rst_busy", busy_v[0], 1);
        resetn = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        #1;
        check_reset(0);
        resetn        = 1'b1;
        in_valid_v[0] = 1'b0;
        $display("op dut=0 reset asserted mid-issue");
    endtask

    initial begin
        resetn      = 1'b0;
        start_v     = '0;
        in_valid_v  = '0;
        out_ready_v = '0;
        for (int i = 0; i < 2; i++) begin
            vec_len_v[i] = '0;
            in_a_v[i]    = 0;
            in_b_v[i]    = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        resetn = 1'b1;

        run_op(0, 3, 0, 0, 1'b0);
        run_op(0, 0, 1, 1, 1'b0);
        run_op(0, 2, 2, 4, 1'b0);
        reset_mid_op();
        run_op(0, 5, 1, 2, 1'b0);
        run_op(0, 1, 0, 0, 1'b0);
        idle(0, 2);
        run_op(1, 4, 0, 0, 1'b1);
        check_val("t5_ten", out_result_v[1], 32'h4120_0000);

        for (int r = 0; r < 30; r++) begin
            int d;
            d = int'($urandom_range(0, 1));
            run_op(d, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
